// File: rtl/btb_resolve_queue_if.sv
// Fetch/execute/BTB-training bundle around the BTB resolve queue.
// Latency: n/a (wires only); the queue registers its outputs one cycle after resolve.
// Backpressure: full/empty/count are advisory; a push while full without a pop is dropped.
// Ports: master = fetch/execute side (drives push + resolve, observes training),
//        slave  = queue side (consumes push + resolve, drives training/flush/status).
interface btb_resolve_queue_if #(
  parameter int PTR_W = 2
);
  // fetch side
  logic             fetch_push;
  logic [31:0]      fetch_pc;
  logic             pred_valid;
  logic             pred_taken;
  logic [31:0]      pred_target;
  // execute side
  logic             resolve_valid;
  logic             resolve_is_branch;
  logic             resolve_taken;
  logic [31:0]      resolve_target;
  // status
  logic             full;
  logic             empty;
  logic [PTR_W:0]   count;
  // BTB training / redirect
  logic             update;
  logic [31:0]      update_pc;
  logic [31:0]      update_target;
  logic             mispredicted;
  logic             flush;
  logic [31:0]      redirect_pc;
  logic [15:0]      mispredict_cnt;

  modport master (
    output fetch_push, fetch_pc, pred_valid, pred_taken, pred_target,
    output resolve_valid, resolve_is_branch, resolve_taken, resolve_target,
    input  full, empty, count,
    input  update, update_pc, update_target, mispredicted, flush, redirect_pc,
    input  mispredict_cnt
  );

  modport slave (
    input  fetch_push, fetch_pc, pred_valid, pred_taken, pred_target,
    input  resolve_valid, resolve_is_branch, resolve_taken, resolve_target,
    output full, empty, count,
    output update, update_pc, update_target, mispredicted, flush, redirect_pc,
    output mispredict_cnt
  );
endinterface

// File: rtl/btb_resolve_queue.sv
// In-order queue of fetch-time BTB predictions; resolves the oldest against execute and trains the BTB.
// Latency: 1 cycle from resolve to update/flush pulse; status outputs reflect current occupancy.
// Backpressure: push on full without a same-cycle pop is dropped; resolve on empty is ignored.
// Ports: clk, rst (async active-high); bus (slave modport of btb_resolve_queue_if) carries
//        push/prediction inputs, resolve inputs, status, BTB training and redirect outputs.
module btb_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  btb_resolve_queue_if.slave   bus
);

  // entry storage; contents are only meaningful between the pointers, so no reset
  logic [31:0] pc_q  [DEPTH];
  logic        pv_q  [DEPTH];
  logic        pt_q  [DEPTH];
  logic [31:0] tgt_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic        update_q, update_d;
  logic        mispred_q, mispred_d;
  logic        flush_q, flush_d;
  logic [31:0] upd_pc_q, upd_pc_d;
  logic [31:0] upd_tgt_q, upd_tgt_d;
  logic [31:0] redir_q, redir_d;
  logic [15:0] mis_cnt_q, mis_cnt_d;

  logic        full_w, empty_w;
  logic        pop, push, wr_en;
  logic [31:0] e_pc, e_tgt;
  logic        e_pv, e_pt;
  logic        pt, at, mis;

  always_comb begin
    full_w  = (count_q == (PTR_W+1)'(DEPTH));
    empty_w = (count_q == '0);
    pop     = bus.resolve_valid & ~empty_w;
    // a pop frees a slot in the same cycle, so a full queue can still accept
    push    = bus.fetch_push & (~full_w | pop);

    e_pc  = pc_q[rd_ptr_q];
    e_pv  = pv_q[rd_ptr_q];
    e_pt  = pt_q[rd_ptr_q];
    e_tgt = tgt_q[rd_ptr_q];

    pt  = e_pv & e_pt;
    at  = bus.resolve_is_branch & bus.resolve_taken;
    mis = pop & ((pt != at) | (pt & at & (e_tgt != bus.resolve_target)));

    // a mispredict squashes this cycle's fetch too: it is on the wrong path
    wr_en = push & ~mis;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    update_d  = 1'b0;
    mispred_d = 1'b0;
    flush_d   = 1'b0;
    upd_pc_d  = upd_pc_q;
    upd_tgt_d = upd_tgt_q;
    redir_d   = redir_q;
    mis_cnt_d = mis_cnt_q;

    if (pop) begin
      update_d  = bus.resolve_is_branch | e_pv;
      mispred_d = mis;
      flush_d   = mis;
      // data outputs only move when a training pulse goes out
      if (update_d) begin
        upd_pc_d  = e_pc;
        upd_tgt_d = bus.resolve_target;
        redir_d   = at ? bus.resolve_target : (e_pc + 32'd4);
      end
      if (mis && (mis_cnt_q != 16'hFFFF)) begin
        mis_cnt_d = mis_cnt_q + 16'd1;
      end
    end

    if (mis) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_q[wr_ptr_q]  <= bus.fetch_pc;
      pv_q[wr_ptr_q]  <= bus.pred_valid;
      pt_q[wr_ptr_q]  <= bus.pred_taken;
      tgt_q[wr_ptr_q] <= bus.pred_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      update_q  <= 1'b0;
      mispred_q <= 1'b0;
      flush_q   <= 1'b0;
      upd_pc_q  <= '0;
      upd_tgt_q <= '0;
      redir_q   <= '0;
      mis_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      update_q  <= update_d;
      mispred_q <= mispred_d;
      flush_q   <= flush_d;
      upd_pc_q  <= upd_pc_d;
      upd_tgt_q <= upd_tgt_d;
      redir_q   <= redir_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign bus.full           = full_w;
  assign bus.empty          = empty_w;
  assign bus.count          = count_q;
  assign bus.update         = update_q;
  assign bus.update_pc      = upd_pc_q;
  assign bus.update_target  = upd_tgt_q;
  assign bus.mispredicted   = mispred_q;
  assign bus.flush          = flush_q;
  assign bus.redirect_pc    = redir_q;
  assign bus.mispredict_cnt = mis_cnt_q;

endmodule
